// File: rtl/fifo_pkg.sv
// Shared definitions for the byte fifo and its word packer: byte width and packer state encoding.
package fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Purpose: pops bytes from a show-ahead fifo and packs LANES of them (lane 0 first) into one word with a keep mask.
// Latency: last byte popped at edge N -> out_valid visible in cycle N+1; partial words on idle timeout or flush.
// Backpressure: while a word is held (out_valid && !out_ready) no bytes are popped and the word stays stable.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH     = BYTE_W,
    parameter int LANES     = 4,
    parameter int LOG2LANES = 2,
    parameter int TIMEOUT   = 16,
    parameter int LOG2TMO   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [WIDTH-1:0]         fifo_dataout,
    output logic                     fifo_pop,
    input  logic                     flush,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic [LANES-1:0]         out_keep,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [LOG2LANES-1:0] LAST_IDX = LOG2LANES'(LANES - 1);
    localparam logic [LOG2TMO-1:0]   TMO_M1   = LOG2TMO'(TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LOG2LANES-1:0]     r_idx;
    logic [LOG2TMO-1:0]       r_timer;
    logic [WIDTH*LANES-1:0]   r_lanes;
    logic [LANES-1:0]         r_keep;

    logic w_pop;
    logic w_last;
    logic w_tmo;
    logic w_flush;
    logic w_accept;
    logic w_tmr_sat;

    assign w_tmr_sat = &r_timer;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_last      = 1'b0;
        w_tmo       = 1'b0;
        w_flush     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            FILL: begin
                // The fifo has no underflow guard, so pop strictly follows !empty.
                w_pop   = !fifo_empty && !rst;
                w_last  = w_pop && (r_idx == LAST_IDX);
                w_tmo   = (TIMEOUT != 0) && fifo_empty && (r_idx != '0) && (r_timer == TMO_M1);
                w_flush = flush && (w_pop || (r_idx != '0));
                if (w_last || w_tmo || w_flush) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_accept = out_ready;
                if (out_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_timer <= '0;
            r_lanes <= '0;
            r_keep  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx   <= '0;
                r_timer <= '0;
                r_lanes <= '0;
                r_keep  <= '0;
            end else if (w_pop) begin
                r_lanes[r_idx*WIDTH +: WIDTH] <= fifo_dataout;
                r_keep[r_idx]                 <= 1'b1;
                r_idx                         <= r_idx + 1'b1;
                r_timer                       <= '0;
            end else if (r_state == FILL) begin
                // Idle timer only runs while a partial word is pending.
                if (r_idx == '0) begin
                    r_timer <= '0;
                end else if (fifo_empty && !w_tmr_sat) begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    assign fifo_pop  = w_pop;
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_lanes;
    assign out_keep  = r_keep;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-modelled show-ahead fifo, directed scenarios and a random byte-stream scoreboard.
module tb_fifo_word_packer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_dataout;
    logic        fifo_pop;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;

    fifo_word_packer #(
        .WIDTH(8), .LANES(4), .LOG2LANES(2), .TIMEOUT(16), .LOG2TMO(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_pop     (fifo_pop),
        .flush        (flush),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  q[$];
    logic [7:0]  exp_bytes[$];
    bit          g_track = 1'b0;

    logic        s_pop, s_valid, s_empty;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;

    task automatic fifo_sync();
        fifo_empty   = (q.size() == 0);
        fifo_dataout = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        if (g_track) exp_bytes.push_back(b);
        fifo_sync();
    endtask

    // One clock cycle: drive at negedge, sample before posedge, retire the fifo pop after posedge.
    task automatic tick(input bit fl, input bit rdy);
        logic [7:0] e;
        flush     = fl;
        out_ready = rdy;
        #1;
        s_pop   = fifo_pop;
        s_valid = out_valid;
        s_empty = fifo_empty;
        s_data  = out_data;
        s_keep  = out_keep;
        n_checks++;
        if (s_pop && s_empty) begin
            n_errors++;
            $display("FAIL pop_while_empty: fifo_pop=%0b fifo_empty=%0b required pop=0", s_pop, s_empty);
        end
        if (s_valid) begin
            n_checks++;
            if (s_pop !== 1'b0) begin
                n_errors++;
                $display("FAIL pop_in_hold: fifo_pop=%0b required 0", s_pop);
            end
        end
        if (prev_hold) begin
            n_checks++;
            if (s_valid !== 1'b1 || s_data !== prev_data || s_keep !== prev_keep) begin
                n_errors++;
                $display("FAIL hold_stable: valid=%0b data=%h keep=%b required valid=1 data=%h keep=%b",
                         s_valid, s_data, s_keep, prev_data, prev_keep);
            end
        end
        prev_hold = s_valid && !rdy && !rst;
        prev_data = s_data;
        prev_keep = s_keep;
        if (g_track && s_valid && rdy && !rst) begin
            n_checks++;
            if (!(s_keep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
                n_errors++;
                $display("FAIL keep_shape: keep=%b required contiguous non-empty mask", s_keep);
            end
            for (int l = 0; l < 4; l++) begin
                n_checks++;
                if (s_keep[l]) begin
                    e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
                    if (s_data[l*8 +: 8] !== e) begin
                        n_errors++;
                        $display("FAIL stream_lane%0d: got %h required %h", l, s_data[l*8 +: 8], e);
                    end
                end else if (s_data[l*8 +: 8] !== 8'h00) begin
                    n_errors++;
                    $display("FAIL unfilled_lane%0d: got %h required 00", l, s_data[l*8 +: 8]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_pop && q.size() != 0) void'(q.pop_front());
        fifo_sync();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = -1;
        for (int c = 0; c < max; c++) begin
            tick(1'b0, 1'b0);
            if (s_valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push(8'h99);
        tick(1'b0, 1'b0);
        n_checks++;
        if (s_pop !== 1'b0 || s_valid !== 1'b0 || s_data !== 32'h0 || s_keep !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_state: pop=%0b valid=%0b data=%h keep=%b required 0 0 00000000 0000",
                     s_pop, s_valid, s_data, s_keep);
        end
        q.delete();
        fifo_sync();
        rst = 1'b0;
        tick(1'b0, 1'b0);
        n_checks++;
        if (s_valid !== 1'b0 || s_keep !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_release: valid=%0b keep=%b required 0 0000", s_valid, s_keep);
        end
    endtask

    task automatic test_full_word();
        int last_pop = -1;
        int first_vld = -1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b0);
            if (s_pop) last_pop = c;
            if (s_valid) begin
                first_vld = c;
                break;
            end
        end
        n_checks++;
        if (first_vld < 0 || first_vld != last_pop + 1) begin
            n_errors++;
            $display("FAIL full_latency: valid at cycle %0d required %0d", first_vld, last_pop + 1);
        end
        n_checks++;
        if (s_data !== 32'h44332211 || s_keep !== 4'b1111) begin
            n_errors++;
            $display("FAIL full_word: data=%h keep=%b required 44332211 1111", s_data, s_keep);
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        n_checks++;
        if (s_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL after_accept: valid=%0b required 0", s_valid);
        end
    endtask

    task automatic test_timeout();
        int idle = 0;
        bit seen = 1'b0;
        push(8'hA1); push(8'hA2);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            tick(1'b0, 1'b0);
            if (s_valid) begin
                seen = 1'b1;
                break;
            end
            idle++;
        end
        n_checks++;
        if (!seen || idle != 16) begin
            n_errors++;
            $display("FAIL timeout_cycles: empty cycles before valid=%0d seen=%0b required 16", idle, seen);
        end
        n_checks++;
        if (s_data !== 32'h0000A2A1 || s_keep !== 4'b0011) begin
            n_errors++;
            $display("FAIL timeout_word: data=%h keep=%b required 0000a2a1 0011", s_data, s_keep);
        end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_flush();
        int cyc;
        bit any_vld = 1'b0;
        push(8'h55);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== 32'h00000055 || s_keep !== 4'b0001) begin
            n_errors++;
            $display("FAIL flush_word: valid=%0b data=%h keep=%b required 1 00000055 0001",
                     s_valid, s_data, s_keep);
        end
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b0);
            if (s_valid) any_vld = 1'b1;
        end
        n_checks++;
        if (any_vld) begin
            n_errors++;
            $display("FAIL flush_idle: out_valid=1 seen, required no word");
        end
        cyc = 0;
    endtask

    task automatic test_backpressure();
        int cyc;
        bit bad = 1'b0;
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        wait_valid(12, cyc);
        n_checks++;
        if (cyc < 0 || s_data !== 32'h13121110) begin
            n_errors++;
            $display("FAIL bp_first_word: cyc=%0d data=%h required 13121110", cyc, s_data);
        end
        push(8'h20); push(8'h21); push(8'h22); push(8'h23);
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (s_pop !== 1'b0 || s_valid !== 1'b1 || s_data !== 32'h13121110 || s_keep !== 4'b1111) begin
                n_errors++;
                $display("FAIL bp_hold: pop=%0b valid=%0b data=%h keep=%b required 0 1 13121110 1111",
                         s_pop, s_valid, s_data, s_keep);
            end
        end
        tick(1'b0, 1'b1);
        n_checks++;
        if (s_pop !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_accept_pop: pop=%0b required 0", s_pop);
        end
        wait_valid(12, cyc);
        n_checks++;
        if (cyc != 4 || s_data !== 32'h23222120 || s_keep !== 4'b1111) begin
            n_errors++;
            $display("FAIL bp_second_word: cyc=%0d data=%h keep=%b required 4 23222120 1111", cyc, s_data, s_keep);
        end
        tick(1'b0, 1'b1);
        bad = 1'b0;
    endtask

    task automatic test_reset_midword();
        int cyc;
        push(8'hAA); push(8'hBB);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        n_checks++;
        if (s_valid !== 1'b0 || s_keep !== 4'h0 || s_data !== 32'h0) begin
            n_errors++;
            $display("FAIL midword_reset: valid=%0b data=%h keep=%b required 0 00000000 0000", s_valid, s_data, s_keep);
        end
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid(12, cyc);
        n_checks++;
        if (cyc < 0 || s_data !== 32'h04030201 || s_keep !== 4'b1111) begin
            n_errors++;
            $display("FAIL midword_next: data=%h keep=%b required 04030201 1111", s_data, s_keep);
        end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_random();
        int push_pct = 45;
        bit fl, rdy;
        g_track = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (c % 50 == 0) push_pct = ($urandom_range(0, 2) == 0) ? 2 : 45;
            if ($urandom_range(0, 99) < push_pct && q.size() < 16) push(8'($urandom));
            fl  = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 60);
            tick(fl, rdy);
        end
        for (int c = 0; c < 200; c++) begin
            if (exp_bytes.size() == 0 && q.size() == 0) break;
            tick(1'b1, 1'b1);
        end
        n_checks++;
        if (exp_bytes.size() != 0 || q.size() != 0) begin
            n_errors++;
            $display("FAIL random_drain: %0d bytes unaccounted, %0d left in fifo, required 0 0",
                     exp_bytes.size(), q.size());
        end
        g_track = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_sync();
        repeat (2) @(negedge clk);
        test_reset();
        test_full_word();
        test_timeout();
        test_flush();
        test_backpressure();
        test_reset_midword();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
